// File: rtl/soc_sim_pkg.sv
// Shared encodings and defaults for the Verilator SoC simulation harness.
package soc_sim_pkg;

    // UART monitor states
    typedef enum logic [1:0] {
        MonIdle,
        MonStart,
        MonData,
        MonStop
    } mon_state_e;

    // Harness sequencing states
    typedef enum logic [1:0] {
        HarnResetHold,
        HarnRun,
        HarnDone
    } harn_state_e;

    // End-of-test signature bytes (ACK / NAK)
    localparam logic [7:0] DefaultPassByte = 8'h06;
    localparam logic [7:0] DefaultFailByte = 8'h15;

endpackage

// File: rtl/rvsteel_soc.sv
// Loopback stand-in for rvsteel_soc so the harness elaborates without the SoC sources.
// Echoes uart_rx onto uart_tx one cycle later; the line idles high in reset and
// freezes while halted, mimicking a stopped core.
module rvsteel_soc #(
    parameter int unsigned CLOCK_FREQUENCY  = 50000000,
    parameter int unsigned UART_BAUD_RATE   = 9600,
    parameter int unsigned MEMORY_SIZE      = 32768,
    parameter string       MEMORY_INIT_FILE = "",
    parameter logic [31:0] BOOT_ADDRESS     = 32'h00000000
) (
    input  logic clock,
    input  logic reset,
    input  logic halt,
    input  logic uart_rx,
    output logic uart_tx
);

    logic uart_tx_q;

    // Registered echo of the host line
    always_ff @(posedge clock) begin
        if (reset) begin
            uart_tx_q <= 1'b1;
        end else if (!halt) begin
            uart_tx_q <= uart_rx;
        end
    end

    assign uart_tx = uart_tx_q;

    // Configuration has no effect on the loopback model
    logic unused_cfg;
    assign unused_cfg = ^{CLOCK_FREQUENCY, UART_BAUD_RATE, MEMORY_SIZE, BOOT_ADDRESS,
                          (MEMORY_INIT_FILE != "")};

endmodule

// File: rtl/uart_sim_monitor.sv
// 8N1 LSB-first UART receiver that watches a serial line and reports decoded bytes.
module uart_sim_monitor
    import soc_sim_pkg::*;
#(
    parameter int unsigned CYCLES_PER_BIT = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       frame_error
);

    localparam int unsigned CntW = $clog2(CYCLES_PER_BIT + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(CYCLES_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfCnt = CntW'(CYCLES_PER_BIT / 2 - 1);

    mon_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            frame_error_q, frame_error_d;

    // State register with synchronous reset; a partial frame is discarded on reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= MonIdle;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    // Next-state: mid-bit sampling driven by a per-bit cycle counter
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        frame_error_d = 1'b0;
        case (state_q)
            MonIdle: begin
                cnt_d = '0;
                if (!rx) begin
                    state_d = MonStart;
                end
            end
            MonStart: begin
                if (cnt_q == HalfCnt) begin
                    cnt_d = '0;
                    if (!rx) begin
                        state_d   = MonData;
                        bit_idx_d = '0;
                    end else begin
                        // Line went back high before mid start bit: glitch
                        state_d = MonIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MonData: begin
                if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    shift_d = {rx, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = MonStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MonStop: begin
                if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    state_d = MonIdle;
                    if (rx) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = MonIdle;
        endcase
    end

    assign rx_valid    = rx_valid_q;
    assign rx_data     = rx_data_q;
    assign frame_error = frame_error_q;

endmodule

// File: rtl/soc_sim_harness.sv
// Simulation top: sequences SoC reset, decodes its UART output and judges end of test.
module soc_sim_harness
    import soc_sim_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY  = 50000000,
    parameter int unsigned UART_BAUD_RATE   = 9600,
    parameter int unsigned MEMORY_SIZE      = 32768,
    parameter string       MEMORY_INIT_FILE = "",
    parameter logic [31:0] BOOT_ADDRESS     = 32'h00000000,
    parameter int unsigned RESET_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES   = 1000000,
    parameter logic [7:0]  PASS_BYTE        = DefaultPassByte,
    parameter logic [7:0]  FAIL_BYTE        = DefaultFailByte
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        halt,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic        frame_error,
    output logic        test_done,
    output logic        test_pass,
    output logic        test_timeout,
    output logic [31:0] cycle_count
);

    // Monitor needs at least 4 cycles per bit for a meaningful mid-bit sample
    localparam int unsigned CyclesPerBit = CLOCK_FREQUENCY / UART_BAUD_RATE;
    localparam logic [31:0] HoldLast     = 32'(RESET_CYCLES - 1);
    localparam bit          TimeoutEn    = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TimeoutLast  = TimeoutEn ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    harn_state_e state_q, state_d;
    logic [31:0] hold_cnt_q, hold_cnt_d;
    logic [31:0] cycle_count_q, cycle_count_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        timeout_q, timeout_d;
    logic        soc_reset;
    logic        soc_halt;

    // Harness reset reaches the SoC combinationally so it is reasserted in the same cycle
    assign soc_reset = reset | (state_q == HarnResetHold);
    assign soc_halt  = halt | (state_q == HarnDone);

    rvsteel_soc #(
        .CLOCK_FREQUENCY  (CLOCK_FREQUENCY),
        .UART_BAUD_RATE   (UART_BAUD_RATE),
        .MEMORY_SIZE      (MEMORY_SIZE),
        .MEMORY_INIT_FILE (MEMORY_INIT_FILE),
        .BOOT_ADDRESS     (BOOT_ADDRESS)
    ) u_soc (
        .clock   (clock),
        .reset   (soc_reset),
        .halt    (soc_halt),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx)
    );

    uart_sim_monitor #(
        .CYCLES_PER_BIT (CyclesPerBit)
    ) u_monitor (
        .clock       (clock),
        .reset       (reset),
        .rx          (uart_tx),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .frame_error (frame_error)
    );

    // Harness state and sticky result flags
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= HarnResetHold;
            hold_cnt_q    <= '0;
            cycle_count_q <= '0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            cycle_count_q <= cycle_count_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            timeout_q     <= timeout_d;
        end
    end

    // Next-state: reset hold, run with byte/timeout judging, then frozen done
    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        cycle_count_d = cycle_count_q;
        done_d        = done_q;
        pass_d        = pass_q;
        timeout_d     = timeout_q;
        case (state_q)
            HarnResetHold: begin
                if (hold_cnt_q == HoldLast) begin
                    hold_cnt_d = '0;
                    state_d    = HarnRun;
                end else begin
                    hold_cnt_d = hold_cnt_q + 32'd1;
                end
            end
            HarnRun: begin
                // Signature bytes take priority over a coincident timeout; the count
                // freezes on the transition edge so a timeout reports TIMEOUT_CYCLES-1
                if (rx_valid && (rx_data == PASS_BYTE)) begin
                    state_d = HarnDone;
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
                end else if (rx_valid && (rx_data == FAIL_BYTE)) begin
                    state_d = HarnDone;
                    done_d  = 1'b1;
                    pass_d  = 1'b0;
                end else if (TimeoutEn && (cycle_count_q == TimeoutLast)) begin
                    state_d   = HarnDone;
                    done_d    = 1'b1;
                    pass_d    = 1'b0;
                    timeout_d = 1'b1;
                end else if (cycle_count_q != 32'hFFFF_FFFF) begin
                    cycle_count_d = cycle_count_q + 32'd1;
                end
            end
            HarnDone: begin
                state_d = HarnDone;
            end
            default: state_d = HarnResetHold;
        endcase
    end

    assign test_done    = done_q;
    assign test_pass    = pass_q;
    assign test_timeout = timeout_q;
    assign cycle_count  = cycle_count_q;

endmodule
